freq_gate_seq: RTL
==================

FREQ_GATE_SEQ -- requirements
Module: freq_gate_seq

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 25_000_000: clk_25MHz frequency in Hz, used as the 1 s gate length in cycles.
REQ-002 The block SHALL have parameter CLR_CYC, default 4: cycles clr is held high.
REQ-003 The block SHALL have parameter SETTLE_CYC, default 8: cycles between gate close and latch, for counter clock-domain settling.
REQ-004 The block SHALL have port clk_25MHz, input, 1: the only clock; every register updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 The block SHALL have port run, input, 1: level; 1 requests continuous back-to-back measurements.
REQ-007 The block SHALL have port gate_sel, input, 2: gate length; 0=CLK_HZ, 1=CLK_HZ/10, 2=CLK_HZ/100, 3=CLK_HZ/1000 cycles.
REQ-008 The block SHALL have ports mode_a and mode_b, input, 1 each: per channel, 1=frequency measurement, 0=channel idle (encoder display).
REQ-009 The block SHALL have ports cnt_a and cnt_b, input, 32 each: 8-digit BCD counts from the external frequency counters.
REQ-010 The block SHALL have ports gate_a and gate_b, output, 1 each: count enable to each counter.
REQ-011 The block SHALL have port clr, output, 1: clear to both counters.
REQ-012 The block SHALL have ports res_a and res_b, output, 32 each: latched BCD results.
REQ-013 The block SHALL have port res_valid, output, 1: one-cycle pulse when results update.
REQ-014 The block SHALL have ports ovf_a and ovf_b, output, 1 each: set when the latched result is 32'h9999_9999.
REQ-015 The block SHALL have port gate_code, output, 2: the gate_sel value used for the current results (display decimal point).
REQ-016 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, GATE, SETTLE and LATCH.
REQ-018 IDLE: gates low, clr low; if run=1, go to CLEAR next cycle and capture gate_sel, mode_a and mode_b into internal registers.
REQ-019 CLEAR: clr=1 for exactly CLR_CYC cycles, then GATE.
REQ-020 GATE: gate_x=1 only for channels whose captured mode is 1, for exactly the selected period in cycles, then SETTLE.
REQ-021 SETTLE: gates low for exactly SETTLE_CYC cycles, then LATCH.
REQ-022 LATCH lasts 1 cycle and SHALL do all of the following: load res_x from cnt_x for each channel whose captured mode is 1; leave res_x unchanged for mode-0 channels; update ovf_x and gate_code; pulse res_valid for one cycle.
REQ-023 LATCH SHALL go to CLEAR if run=1, recapturing gate_sel and modes; otherwise it goes to IDLE.
REQ-024 If run falls during CLEAR, GATE or SETTLE, the FSM SHALL abort to IDLE on the next cycle: gates and clr low, no res_valid, results retained.
REQ-025 Changes to gate_sel or mode inputs during a measurement SHALL be ignored until the next capture.
REQ-026 The gate timer SHALL be a down-counter of width ceil(log2(CLK_HZ))+1, loaded with period-1 and terminating at 0 with no wrap-around.
REQ-027 With both captured modes 0, the FSM SHALL still cycle normally and pulse res_valid, but no results change.
REQ-028 If reset and run are both asserted, reset SHALL win.

Reset
REQ-029 On reset the FSM SHALL enter IDLE, and these outputs SHALL go to 0: gate_a, gate_b, clr, res_valid, busy, ovf_a, ovf_b, gate_code.
REQ-030 On reset res_a and res_b SHALL go to 32'h0, and all timers SHALL clear to 0.
REQ-031 Reset asserted mid-GATE SHALL drop the gates on the following cycle.

Structure
REQ-032 Package freq_gate_pkg SHALL hold the state enumeration, the gate_sel encodings and the divide constants 1/10/100/1000.
REQ-033 The gate down-counter SHALL be a sub-module gate_timer, with ports load, value, en and done.
REQ-034 Output registers SHALL be direct flops with no combinational path from input to output.

Verification (CLK_HZ=10000, CLR_CYC=4, SETTLE_CYC=8)
REQ-035 Scenario: run=1, gate_sel=2, mode_a=1, mode_b=1 -> clr high 4 cycles, gate_a and gate_b high exactly 100 cycles, res_valid 8 cycles after gate falls.
REQ-036 Scenario: cnt_a=32'h0001_2345 held during LATCH, mode_b=0 -> res_a=32'h0001_2345, res_b unchanged, gate_b never high.
REQ-037 Scenario: run dropped at gate cycle 50 of gate_sel=1 -> IDLE next cycle, no res_valid, results retained.
REQ-038 Scenario: gate_sel changed 3->0 mid-gate -> current gate still 10 cycles; next gate 10000 cycles with gate_code=0.
REQ-039 Scenario: cnt_a=32'h9999_9999 at LATCH -> ovf_a=1; next measurement with 32'h0000_0010 -> ovf_a=0.
REQ-040 Scenario: reset pulsed mid-SETTLE -> all outputs 0 next cycle; a new measurement starts in the cycle after reset is released.

Source files
------------

// File: rtl/freq_gate_pkg.sv
// Shared types and constants for the frequency-counter gate sequencer.
//   fsm_state_e  : sequencer states
//   GSEL_*       : gate_sel encodings (gate length selector)
//   DIV_*        : divisors applied to CLK_HZ for each gate length
//   gate_period  : gate length in clock cycles for a given selector
package freq_gate_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_GATE,
      ST_SETTLE,
      ST_LATCH
   } fsm_state_e;

   localparam logic [1:0] GSEL_1S    = 2'd0;
   localparam logic [1:0] GSEL_100MS = 2'd1;
   localparam logic [1:0] GSEL_10MS  = 2'd2;
   localparam logic [1:0] GSEL_1MS   = 2'd3;

   localparam int unsigned DIV_1S    = 1;
   localparam int unsigned DIV_100MS = 10;
   localparam int unsigned DIV_10MS  = 100;
   localparam int unsigned DIV_1MS   = 1000;

   // Saturated 8-digit BCD count reported by the external counters.
   localparam logic [31:0] OVF_VAL = 32'h9999_9999;

   function automatic int unsigned gate_period(input int unsigned clk_hz,
                                               input logic [1:0]  sel);
      int unsigned p;
      p = clk_hz / DIV_1S;
      case (sel)
         GSEL_1S:    p = clk_hz / DIV_1S;
         GSEL_100MS: p = clk_hz / DIV_100MS;
         GSEL_10MS:  p = clk_hz / DIV_10MS;
         GSEL_1MS:   p = clk_hz / DIV_1MS;
         default:    p = clk_hz / DIV_1S;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/gate_timer.sv
// Gate-length down-counter.
//   clk_25MHz : clock
//   reset     : synchronous active-high, clears the count
//   load      : load value (period-1) into the counter
//   value     : load value
//   en        : count down by one per cycle, holding at zero
//   done      : count is zero (last gate cycle when counting)
module gate_timer #(
   parameter int unsigned W = 26
) (
   input  logic         clk_25MHz,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_25MHz) begin
      if (reset)
         cnt_q <= '0;
      else if (load)
         cnt_q <= value;
      else if (en && (cnt_q != '0))
         cnt_q <= cnt_q - 1'b1;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/freq_gate_seq.sv
// Measurement sequencer for two external BCD frequency counters:
// clear -> gate (selected period) -> settle -> latch, repeating while run=1.
//   clk_25MHz, reset     : clock, synchronous active-high reset
//   run                  : level request for back-to-back measurements
//   gate_sel             : gate length (CLK_HZ / 1, 10, 100, 1000 cycles)
//   mode_a, mode_b       : 1 = channel measures frequency, 0 = channel idle
//   cnt_a, cnt_b         : BCD counts from the external counters
//   gate_a, gate_b, clr  : counter enable / clear
//   res_a, res_b         : latched BCD results
//   res_valid            : one-cycle pulse coincident with a result update
//   ovf_a, ovf_b         : latched result is 9999_9999
//   gate_code            : gate_sel used for the current results
//   busy                 : sequencer not idle
module freq_gate_seq
   import freq_gate_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 25_000_000,
   parameter int unsigned CLR_CYC    = 4,
   parameter int unsigned SETTLE_CYC = 8
) (
   input  logic        clk_25MHz,
   input  logic        reset,
   input  logic        run,
   input  logic [1:0]  gate_sel,
   input  logic        mode_a,
   input  logic        mode_b,
   input  logic [31:0] cnt_a,
   input  logic [31:0] cnt_b,
   output logic        gate_a,
   output logic        gate_b,
   output logic        clr,
   output logic [31:0] res_a,
   output logic [31:0] res_b,
   output logic        res_valid,
   output logic        ovf_a,
   output logic        ovf_b,
   output logic [1:0]  gate_code,
   output logic        busy
);

   localparam int unsigned TW = $clog2(CLK_HZ) + 1;

   fsm_state_e    state_q, state_n;
   logic [15:0]   cyc_q, cyc_n;
   logic [1:0]    sel_q;
   logic          ma_q, mb_q;
   logic          capture;
   logic          t_load, t_en, t_done;
   logic [TW-1:0] t_value;
   logic [31:0]   lat_a, lat_b;

   gate_timer #(.W(TW)) u_gate_timer (
      .clk_25MHz (clk_25MHz),
      .reset     (reset),
      .load      (t_load),
      .value     (t_value),
      .en        (t_en),
      .done      (t_done)
   );

   assign t_value = TW'(gate_period(CLK_HZ, sel_q) - 1);
   assign t_en    = (state_q == ST_GATE);

   always_comb begin
      state_n = state_q;
      cyc_n   = cyc_q;
      capture = 1'b0;
      t_load  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_n = ST_CLEAR;
               cyc_n   = 16'(CLR_CYC - 1);
               capture = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (!run)
               state_n = ST_IDLE;
            else if (cyc_q == '0) begin
               state_n = ST_GATE;
               t_load  = 1'b1;
            end else
               cyc_n = cyc_q - 16'd1;
         end
         ST_GATE: begin
            if (!run)
               state_n = ST_IDLE;
            else if (t_done) begin
               state_n = ST_SETTLE;
               cyc_n   = 16'(SETTLE_CYC - 1);
            end
         end
         ST_SETTLE: begin
            if (!run)
               state_n = ST_IDLE;
            else if (cyc_q == '0)
               state_n = ST_LATCH;
            else
               cyc_n = cyc_q - 16'd1;
         end
         ST_LATCH: begin
            if (run) begin
               state_n = ST_CLEAR;
               cyc_n   = 16'(CLR_CYC - 1);
               capture = 1'b1;
            end else
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Value each result register takes on latch; idle channels keep theirs.
   always_comb begin
      lat_a = ma_q ? cnt_a : res_a;
      lat_b = mb_q ? cnt_b : res_b;
   end

   // Outputs are registered from the next-state decode so they line up with
   // the state register. The result load happens on the edge entering LATCH,
   // so res_x and res_valid change together during the LATCH cycle.
   always_ff @(posedge clk_25MHz) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cyc_q     <= '0;
         sel_q     <= '0;
         ma_q      <= 1'b0;
         mb_q      <= 1'b0;
         gate_a    <= 1'b0;
         gate_b    <= 1'b0;
         clr       <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         res_a     <= '0;
         res_b     <= '0;
         ovf_a     <= 1'b0;
         ovf_b     <= 1'b0;
         gate_code <= '0;
      end else begin
         state_q   <= state_n;
         cyc_q     <= cyc_n;
         if (capture) begin
            sel_q <= gate_sel;
            ma_q  <= mode_a;
            mb_q  <= mode_b;
         end
         gate_a    <= (state_n == ST_GATE) && ma_q;
         gate_b    <= (state_n == ST_GATE) && mb_q;
         clr       <= (state_n == ST_CLEAR);
         res_valid <= (state_n == ST_LATCH);
         busy      <= (state_n != ST_IDLE);
         if (state_n == ST_LATCH) begin
            res_a     <= lat_a;
            res_b     <= lat_b;
            ovf_a     <= (lat_a == OVF_VAL);
            ovf_b     <= (lat_b == OVF_VAL);
            gate_code <= sel_q;
         end
      end
   end

endmodule
